regbank_writeback: RTL and testbench
====================================

REGBANK_WRITEBACK -- requirements
Module: regbank_writeback

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port alu_we, input, 1 bit: single-cycle pipeline result valid (never stalled).
REQ-004 The block SHALL have the port alu_addr, input, 4 bits: destination register of the pipeline result.
REQ-005 The block SHALL have the port alu_data, input, 32 bits: pipeline result data.
REQ-006 The block SHALL have the port mem_valid, input, 1 bit: multi-cycle (load/divide) result offered.
REQ-007 The block SHALL have the port mem_addr, input, 4 bits: destination register of the multi-cycle result.
REQ-008 The block SHALL have the port mem_data, input, 32 bits: multi-cycle result data.
REQ-009 The block SHALL have the port mem_ready, output, 1 bit: FIFO can accept a result this cycle.
REQ-010 The block SHALL have the port pend_set, input, 1 bit: multi-cycle op issued, mark destination pending.
REQ-011 The block SHALL have the port pend_addr, input, 4 bits: register to mark pending.
REQ-012 The block SHALL have the port pending, output, 16 bits: per-register pending flags for the issue stall logic.
REQ-013 The block SHALL have the port addr_d, output, 4 bits: register-bank write address.
REQ-014 The block SHALL have the port data_d, output, 32 bits: register-bank write data.
REQ-015 The block SHALL have the port we, output, 1 bit: register-bank write enable.
REQ-016 The block SHALL have the port fifo_count, output, 3 bits: multi-cycle FIFO occupancy, 0..4.
REQ-017 The block SHALL have the parameter FIFO_DEPTH, default 4: multi-cycle result FIFO depth, power of two.

Function
REQ-018 The block SHALL register addr_d, data_d and we, so each is driven from a flop.
REQ-019 The block SHALL drive the alu_we/alu_addr/alu_data of cycle N onto we/addr_d/data_d in cycle N+1.
REQ-020 The block SHALL accept a mem transfer on a cycle where mem_valid and mem_ready are both high, and SHALL push it into the FIFO.
REQ-021 The block SHALL derive mem_ready combinationally from occupancy: high iff fifo_count < FIFO_DEPTH.
REQ-022 The block SHALL pop the FIFO head in a cycle iff the FIFO is non-empty and alu_we is low; the pipeline path has strict priority.
REQ-023 The block SHALL drive a popped head onto we/addr_d/data_d in the following cycle; minimum mem latency is 2 cycles (push in cycle N -> we in cycle N+2).
REQ-024 The block SHALL leave fifo_count unchanged on a simultaneous push and pop; the count SHALL never exceed FIFO_DEPTH or underflow.
REQ-025 The block SHALL keep read and write pointers as log2(FIFO_DEPTH)-bit counters that wrap modulo FIFO_DEPTH.
REQ-026 The block SHALL force we=0 for any write whose address is 0; the write SHALL still be consumed (popped or dropped).
REQ-027 The block SHALL set pending[pend_addr] when pend_set=1 and pend_addr!=0; pending[0] SHALL be constant 0.
REQ-028 The block SHALL clear pending[a] on the edge at which a FIFO entry with address a is popped.
REQ-029 On a simultaneous pend_set and pop to the same address, set SHALL win.
REQ-030 ALU-path writes SHALL NOT affect pending.
REQ-031 Without reset the block SHALL have no idle/hold state; we SHALL be 0 in any cycle following one with neither alu_we nor a pop.

Reset
REQ-032 On reset the block SHALL drive we=0, addr_d=0, data_d=0, pending=0, fifo_count=0, and pointers to 0; mem_ready SHALL be 1 in the cycle after reset.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents and pending flags; inputs during reset cycles SHALL be ignored.
REQ-034 FIFO data storage SHALL NOT be reset (RAM-inferable).

Structure
REQ-035 FIFO_DEPTH and the register-index width (4) SHALL be constants in the shared cpu package.
REQ-036 The FIFO SHALL be one sub-module, wb_fifo (push/pop, count, full/empty); arbitration, output register and pending scoreboard SHALL be in the top level.

Verification
REQ-037 The bench SHALL verify: alu_we=1, alu_addr=5, alu_data=0xDEADBEEF in cycle 1 -> we=1, addr_d=5, data_d=0xDEADBEEF in cycle 2 only.
REQ-038 The bench SHALL verify: pend_set on reg 3, later mem push (3, 0x12) with alu idle -> pending[3]=1 until the pop edge, then we with (3, 0x12) two cycles after the push, then pending[3]=0.
REQ-039 The bench SHALL verify: 5 consecutive mem_valid with alu_we held high -> 4 accepted, mem_ready=0 on the fifth, fifo_count=4; alu_we dropped -> 4 writes in push order on consecutive cycles.
REQ-040 The bench SHALL verify: alu_we and non-empty FIFO in the same cycle -> ALU write first, FIFO head next cycle.
REQ-041 The bench SHALL verify: write to register 0 on both paths -> we stays 0, FIFO entry still consumed.
REQ-042 The bench SHALL verify: reset with fifo_count=3 and pending=0x0010 -> next cycle fifo_count=0, pending=0, we=0, no stale writes afterwards.

Source files
------------

// File: rtl/regbank_writeback_pkg.sv
// Shared constants and types for the register-bank writeback stage.
package regbank_writeback_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int REG_IDX_W  = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_IDX_W;

  // One buffered multi-cycle result waiting for a free write port slot
  typedef struct packed {
    logic [REG_IDX_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // Which source owns the register-bank write port in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regbank_writeback_fifo.sv
// Small result FIFO for multi-cycle (load/divide) writebacks.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [3:0]               push_addr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [3:0]               head_addr,
  output logic [31:0]              head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import regbank_writeback_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = storage[rd_ptr].addr;
  assign head_data = storage[rd_ptr].data;

  // Storage array is deliberately left unreset so it can map onto a RAM
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      storage[wr_ptr] <= '{addr: push_addr, data: push_data};
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regbank_writeback.sv
// Writeback stage: merges the single-cycle pipeline result with buffered
// multi-cycle results onto one register-bank write port, and keeps a
// per-register pending scoreboard for the issue stall logic.
module regbank_writeback #(
  parameter int FIFO_DEPTH = regbank_writeback_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_we,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        pend_set,
  input  logic [3:0]  pend_addr,
  output logic [15:0] pending,
  output logic [3:0]  addr_d,
  output logic [31:0] data_d,
  output logic        we,
  output logic [2:0]  fifo_count
);
  import regbank_writeback_pkg::*;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic [REG_IDX_W-1:0]          head_addr;
  logic [DATA_W-1:0]             head_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_occupancy;
  logic [NUM_REGS-1:0]           pending_q;
  logic [NUM_REGS-1:0]           pending_next;
  wb_src_e                       wb_src;

  assign mem_ready  = !fifo_full;
  assign fifo_push  = mem_valid && mem_ready;
  assign fifo_pop   = (wb_src == SRC_FIFO);
  assign fifo_count = 3'(fifo_occupancy);
  assign pending    = pending_q;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (fifo_occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port arbitration: the unstallable pipeline result always wins the slot
  always_comb begin
    wb_src = SRC_NONE;
    if (alu_we) begin
      wb_src = SRC_ALU;
    end else if (!fifo_empty) begin
      wb_src = SRC_FIFO;
    end
  end

  // Registered write port; register 0 is consumed but never written
  always_ff @(posedge clk) begin
    if (reset) begin
      we     <= 1'b0;
      addr_d <= '0;
      data_d <= '0;
    end else begin
      case (wb_src)
        SRC_ALU: begin
          we     <= (alu_addr != '0);
          addr_d <= alu_addr;
          data_d <= alu_data;
        end
        SRC_FIFO: begin
          we     <= (head_addr != '0);
          addr_d <= head_addr;
          data_d <= head_data;
        end
        default: begin
          we <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard update: a pop clears its register, a same-cycle issue re-sets it
  always_comb begin
    pending_next = pending_q;
    if (fifo_pop) begin
      pending_next[head_addr] = 1'b0;
    end
    if (pend_set && (pend_addr != '0)) begin
      pending_next[pend_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Pending flags register, wiped on reset along with the FIFO contents
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

endmodule

// File: tb/tb_regbank_writeback.sv
// Self-checking bench for regbank_writeback: a queue-based behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_regbank_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_we = 1'b0;
  logic [3:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        pend_set = 1'b0;
  logic [3:0]  pend_addr = '0;
  logic [15:0] pending;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t      model_q[$];
  logic        exp_we;
  logic [3:0]  exp_addr;
  logic [31:0] exp_data;
  logic [15:0] exp_pend;
  bit          check_ad;

  always #5 clk = ~clk;

  regbank_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_we     (alu_we),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .pend_set   (pend_set),
    .pend_addr  (pend_addr),
    .pending    (pending),
    .addr_d     (addr_d),
    .data_d     (data_d),
    .we         (we),
    .fifo_count (fifo_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a_we, input logic [3:0] a_addr, input logic [31:0] a_data,
                               input logic m_valid, input logic [3:0] m_addr, input logic [31:0] m_data,
                               input logic p_set, input logic [3:0] p_addr);
    @(negedge clk);
    alu_we    = a_we;
    alu_addr  = a_addr;
    alu_data  = a_data;
    mem_valid = m_valid;
    mem_addr  = m_addr;
    mem_data  = m_data;
    pend_set  = p_set;
    pend_addr = p_addr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: FIFO as a queue, write port as "what wins this cycle"
  always @(posedge clk) begin
    entry_t head;
    entry_t incoming;
    bit     accept;
    if (reset) begin
      model_q.delete();
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_pend = '0;
      check_ad = 1'b1;
    end else begin
      accept   = mem_valid && (model_q.size() < DEPTH);
      check_ad = 1'b0;
      if (alu_we) begin
        exp_we   = (alu_addr != 4'd0);
        exp_addr = alu_addr;
        exp_data = alu_data;
        check_ad = exp_we;
      end else if (model_q.size() > 0) begin
        head     = model_q.pop_front();
        exp_we   = (head.addr != 4'd0);
        exp_addr = head.addr;
        exp_data = head.data;
        exp_pend[head.addr] = 1'b0;
        check_ad = exp_we;
      end else begin
        exp_we = 1'b0;
      end
      if (pend_set && pend_addr != 4'd0) begin
        exp_pend[pend_addr] = 1'b1;
      end
      if (accept) begin
        incoming.addr = mem_addr;
        incoming.data = mem_data;
        model_q.push_back(incoming);
      end
    end
    #1;
    checkOutput("model_we", 32'(we), 32'(exp_we));
    checkOutput("model_pending", 32'(pending), 32'(exp_pend));
    checkOutput("model_fifo_count", 32'(fifo_count), 32'(model_q.size()));
    checkOutput("model_mem_ready", 32'(mem_ready), 32'(model_q.size() < DEPTH));
    if (check_ad) begin
      checkOutput("model_addr_d", 32'(addr_d), 32'(exp_addr));
      checkOutput("model_data_d", data_d, exp_data);
    end
  end

  initial begin
    // Power-on reset
    wait_edge();
    wait_edge();
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_addr_d", 32'(addr_d), 32'd0);
    checkOutput("reset_data_d", data_d, 32'd0);
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
    idle();
    reset = 1'b0;
    #1;
    checkOutput("mem_ready_after_reset", 32'(mem_ready), 32'd1);

    // Pipeline result appears exactly one cycle later, for one cycle
    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    wait_edge();
    checkOutput("alu_we", 32'(we), 32'd1);
    checkOutput("alu_addr_d", 32'(addr_d), 32'd5);
    checkOutput("alu_data_d", data_d, 32'hDEADBEEF);
    idle();
    wait_edge();
    checkOutput("alu_we_drop", 32'(we), 32'd0);

    // Pending flag lifetime around a multi-cycle result
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3);
    wait_edge();
    checkOutput("pend3_set", 32'(pending), 32'h0008);
    idle();
    wait_edge();
    checkOutput("pend3_hold", 32'(pending), 32'h0008);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h12, 1'b0, 4'd0);
    #1;
    checkOutput("pend3_mem_ready", 32'(mem_ready), 32'd1);
    wait_edge();
    checkOutput("pend3_push_we", 32'(we), 32'd0);
    checkOutput("pend3_push_count", 32'(fifo_count), 32'd1);
    checkOutput("pend3_still_set", 32'(pending), 32'h0008);
    idle();
    wait_edge();
    checkOutput("pend3_pop_we", 32'(we), 32'd1);
    checkOutput("pend3_pop_addr", 32'(addr_d), 32'd3);
    checkOutput("pend3_pop_data", data_d, 32'h12);
    checkOutput("pend3_cleared", 32'(pending), 32'h0000);
    idle();
    wait_edge();
    checkOutput("pend3_after_we", 32'(we), 32'd0);

    // Fill FIFO while the pipeline hogs the port, then drain in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd1, 32'(i), 1'b1, 4'(7 + i), 32'h100 + 32'(i), 1'b0, 4'd0);
      #1;
      checkOutput("fill_mem_ready", 32'(mem_ready), (i < 4) ? 32'd1 : 32'd0);
      wait_edge();
      checkOutput("fill_alu_we", 32'(we), 32'd1);
      checkOutput("fill_count", 32'(fifo_count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      wait_edge();
      checkOutput("drain_we", 32'(we), 32'd1);
      checkOutput("drain_addr", 32'(addr_d), 32'(7 + j));
      checkOutput("drain_data", data_d, 32'h100 + 32'(j));
      checkOutput("drain_count", 32'(fifo_count), 32'(3 - j));
    end
    idle();
    wait_edge();
    checkOutput("drain_done_we", 32'(we), 32'd0);

    // ALU beats a waiting FIFO head, head follows next cycle
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
    wait_edge();
    applyStimulus(1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    wait_edge();
    checkOutput("prio_alu_addr", 32'(addr_d), 32'd2);
    checkOutput("prio_alu_data", data_d, 32'h22);
    checkOutput("prio_count_held", 32'(fifo_count), 32'd1);
    idle();
    wait_edge();
    checkOutput("prio_fifo_addr", 32'(addr_d), 32'd6);
    checkOutput("prio_fifo_data", data_d, 32'h66);
    checkOutput("prio_fifo_we", 32'(we), 32'd1);

    // Register 0 writes are swallowed on both paths
    applyStimulus(1'b1, 4'd0, 32'hBAD, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    wait_edge();
    checkOutput("r0_alu_we", 32'(we), 32'd0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hBAD0, 1'b1, 4'd0);
    wait_edge();
    checkOutput("r0_push_count", 32'(fifo_count), 32'd1);
    checkOutput("r0_pending", 32'(pending), 32'd0);
    idle();
    wait_edge();
    checkOutput("r0_pop_we", 32'(we), 32'd0);
    checkOutput("r0_consumed", 32'(fifo_count), 32'd0);

    // Re-issue to a register on the same edge its old result pops: set wins
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd9);
    wait_edge();
    checkOutput("setwin_pend_before", 32'(pending), 32'h0200);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9);
    wait_edge();
    checkOutput("setwin_we", 32'(we), 32'd1);
    checkOutput("setwin_addr", 32'(addr_d), 32'd9);
    checkOutput("setwin_pend_kept", 32'(pending), 32'h0200);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h98, 1'b0, 4'd0);
    wait_edge();
    idle();
    wait_edge();
    checkOutput("setwin_second_data", data_d, 32'h98);
    checkOutput("setwin_pend_cleared", 32'(pending), 32'h0000);

    // Mid-operation reset discards queued results and pending flags
    applyStimulus(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'h2, 1'b1, 4'd4);
    wait_edge();
    applyStimulus(1'b1, 4'd1, 32'hA2, 1'b1, 4'd3, 32'h3, 1'b0, 4'd0);
    wait_edge();
    applyStimulus(1'b1, 4'd1, 32'hA3, 1'b1, 4'd5, 32'h5, 1'b0, 4'd0);
    wait_edge();
    checkOutput("prereset_count", 32'(fifo_count), 32'd3);
    checkOutput("prereset_pending", 32'(pending), 32'h0010);
    applyStimulus(1'b1, 4'd7, 32'h77, 1'b1, 4'd5, 32'h55, 1'b1, 4'd6);
    reset = 1'b1;
    wait_edge();
    checkOutput("midreset_count", 32'(fifo_count), 32'd0);
    checkOutput("midreset_pending", 32'(pending), 32'd0);
    checkOutput("midreset_we", 32'(we), 32'd0);
    idle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_edge();
      checkOutput("postreset_no_stale_we", 32'(we), 32'd0);
      idle();
    end

    wait_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
